// File: rtl/soc_mem_pkg.sv
// -----------------------------------------------------------------------------
// soc_mem_pkg
// Shared types and helpers for the SoC memory responder.
//   data_t / strb_t / addr_t : bus field types (64-bit data, 8 strobes, 32-bit address)
//   rd_tag_t                 : read-pipeline tag {valid, err}
//   strb_to_mask()           : expands byte strobes into a 64-bit bit mask
//   DefaultBaseWord          : word address of the first SRAM word (0x80000000 >> 3)
// -----------------------------------------------------------------------------
package soc_mem_pkg;

   typedef logic [63:0] data_t;
   typedef logic [7:0]  strb_t;
   typedef logic [31:0] addr_t;

   typedef struct packed {
      logic valid;
      logic err;
   } rd_tag_t;

   localparam logic [63:0] DefaultBaseWord = 64'h10000000;

   function automatic data_t strb_to_mask(strb_t strb);
      data_t mask;
      for (int i = 0; i < 8; i++) begin
         mask[i*8 +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/soc_stall_lfsr.sv
// -----------------------------------------------------------------------------
// soc_stall_lfsr
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the grant-stall noise source.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads Seed
//   en    : advance one step per cycle when high
//   state : current LFSR contents
// Seed must be nonzero or the register locks up at all-zeros.
// -----------------------------------------------------------------------------
module soc_stall_lfsr #(
   parameter logic [15:0] Seed = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] state
);

   logic feedback;

   // Right-shifting form: taps 16,14,13,11 map onto bits 0,2,3,5.
   assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];

   // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= Seed;
      end else if (en) begin
         state <= {feedback, state[15:1]};
      end
   end

endmodule

// File: rtl/soc_mem_responder.sv
// -----------------------------------------------------------------------------
// soc_mem_responder
// Memory-side responder between a CPU req/gnt port and an sram_mem instance.
// Adds bounded pseudo-random grant stalls, range checking and a fixed-latency
// read-response pipeline with explicit rvalid.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   stall_en_i             : enable random grant stalls
//   req_i / gnt_o          : request / grant; accepted when both are high
//   addr_i, we_i, wdata_i, strb_i : byte address, write enable, data, strobes
//   rdata_o, rvalid_o, err_o      : read response (err_o = out-of-range read)
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o : SRAM request side
//   mem_rdata_i            : SRAM read data, valid one cycle after mem_req_o
// -----------------------------------------------------------------------------
module soc_mem_responder
   import soc_mem_pkg::*;
#(
   parameter int unsigned Depth       = 1 << 20,
   parameter logic [63:0] BaseWord    = DefaultBaseWord,
   parameter int unsigned ReadLatency = 1,
   parameter logic [15:0] StallSeed   = 16'hACE1,
   parameter int unsigned MaxStall    = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_en_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [63:0] wdata_i,
   input  logic [7:0]  strb_i,
   output logic [63:0] rdata_o,
   output logic        rvalid_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [63:0] mem_wmask_o,
   input  logic [63:0] mem_rdata_i
);

   localparam logic [3:0]  MaxStallCnt = 4'(MaxStall);
   localparam logic [31:0] BaseWord32  = BaseWord[31:0];

   // ---------------------------------------------------------------- grant
   logic [15:0] lfsr;
   logic        stall_raw;
   logic [3:0]  stall_cnt_q;

   soc_stall_lfsr #(.Seed(StallSeed)) u_lfsr (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (1'b1),
      .state (lfsr)
   );

   assign stall_raw = stall_en_i && (lfsr[2:0] == 3'b000);

   // Grant depends only on registered state and stall_en_i, never on req_i.
   // Once stall_cnt reaches MaxStall the stall is overridden, which bounds
   // the wait of a held request to MaxStall+1 cycles.
   assign gnt_o = rst_ni && !(stall_raw && (stall_cnt_q < MaxStallCnt));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else if (req_i && !gnt_o) begin
         stall_cnt_q <= stall_cnt_q + 4'd1;
      end else begin
         stall_cnt_q <= '0;
      end
   end

   // ---------------------------------------------------- acceptance / range
   addr_t word_addr;
   addr_t rel_word;
   logic  in_range;
   logic  accept;

   assign word_addr = {3'b000, addr_i[31:3]};
   // Unsigned wrap makes addresses below the base fail the same single compare.
   assign rel_word  = word_addr - BaseWord32;
   assign in_range  = rel_word < Depth;
   assign accept    = req_i && gnt_o;

   assign mem_req_o   = accept && in_range;
   assign mem_we_o    = we_i;
   assign mem_addr_o  = word_addr;
   assign mem_wdata_o = wdata_i;
   assign mem_wmask_o = strb_to_mask(strb_i);

   // -------------------------------------------------------- read pipeline
   rd_tag_t tag_q [ReadLatency];
   rd_tag_t tag_out;
   data_t   resp_data;
   data_t   rdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ReadLatency; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{valid: accept && !we_i, err: accept && !we_i && !in_range};
         for (int i = 1; i < ReadLatency; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tag_out = tag_q[ReadLatency-1];

   // SRAM data is valid one cycle after acceptance, which lines up with the
   // tag in stage 0; the remaining ReadLatency-1 stages only delay it.
   if (ReadLatency == 1) begin : g_no_delay
      assign resp_data = mem_rdata_i;
   end else begin : g_delay
      data_t dly_q [ReadLatency-1];

      // NOTE: the data delay line has no reset; its contents are only
      // consumed alongside a valid tag, and the tags are reset.
      always_ff @(posedge clk_i) begin
         dly_q[0] <= mem_rdata_i;
         for (int i = 1; i < ReadLatency - 1; i++) begin
            dly_q[i] <= dly_q[i-1];
         end
      end

      assign resp_data = dly_q[ReadLatency-2];
   end

   // Holding register so rdata_o keeps the last response between pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (tag_out.valid) begin
         rdata_q <= tag_out.err ? '0 : resp_data;
      end
   end

   // NOTE: rdata_o gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      rdata_o = rdata_q;
      if (tag_out.valid) begin
         rdata_o = tag_out.err ? '0 : resp_data;
      end
   end

   assign rvalid_o = tag_out.valid;
   assign err_o    = tag_out.valid && tag_out.err;

   // Upper LFSR bits and the byte offset are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{lfsr[15:3], addr_i[2:0]};

endmodule

// File: tb/tb_soc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_soc_mem_responder
// Drives two responders (ReadLatency 1 and 3) with identical stimulus and
// checks them against a byte-addressed reference memory and a queue of
// accepted reads with their due cycles.
// -----------------------------------------------------------------------------
module tb_soc_mem_responder;

   localparam int unsigned DEPTH     = 1 << 20;
   localparam int          MAX_STALL = 3;
   localparam int          LOG_SIZE  = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_en = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [7:0]  strb = '0;

   logic        gnt1, rvalid1, err1;
   logic [63:0] rdata1;
   logic        gnt3, rvalid3, err3;
   logic [63:0] rdata3;

   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata, mem_wmask;
   logic [63:0] mem_rdata = '0;

   logic        mem_req3, mem_we3;
   logic [31:0] mem_addr3;
   logic [63:0] mem_wdata3, mem_wmask3;

   soc_mem_responder #(.ReadLatency(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en),
      .req_i(req), .gnt_o(gnt1), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .strb_i(strb),
      .rdata_o(rdata1), .rvalid_o(rvalid1), .err_o(err1),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
   );

   soc_mem_responder #(.ReadLatency(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en),
      .req_i(req), .gnt_o(gnt3), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .strb_i(strb),
      .rdata_o(rdata3), .rvalid_o(rvalid3), .err_o(err3),
      .mem_req_o(mem_req3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3),
      .mem_wdata_o(mem_wdata3), .mem_wmask_o(mem_wmask3), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // ------------------------------------------------------------ SRAM model
   logic [63:0] sram [logic [31:0]];

   function automatic logic [63:0] sram_rd(input logic [31:0] a);
      return sram.exists(a) ? sram[a] : 64'h0;
   endfunction

   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) sram[mem_addr] = (sram_rd(mem_addr) & ~mem_wmask) | (mem_wdata & mem_wmask);
         else        mem_rdata <= sram_rd(mem_addr);
      end
   end

   // ------------------------------------------------------ reference model
   logic [7:0] ref_bytes [logic [31:0]];

   function automatic logic in_range(input logic [31:0] a);
      return (a >= 32'h8000_0000) && (64'(a) < 64'h8000_0000 + 64'(DEPTH) * 64'd8);
   endfunction

   function automatic logic [63:0] ref_read(input logic [31:0] a);
      logic [63:0] d;
      logic [31:0] ab;
      ab = {a[31:3], 3'b000};
      for (int i = 0; i < 8; i++)
         d[i*8 +: 8] = ref_bytes.exists(ab + 32'(i)) ? ref_bytes[ab + 32'(i)] : 8'h00;
      return d;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      logic [31:0] ab;
      ab = {a[31:3], 3'b000};
      for (int i = 0; i < 8; i++)
         if (s[i]) ref_bytes[ab + 32'(i)] = d[i*8 +: 8];
   endtask

   function automatic logic [63:0] exp_mask(input logic [7:0] s);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   // Preload both the SRAM and the reference with the same word.
   task automatic preload(input logic [31:0] byte_addr, input logic [63:0] d);
      sram[{3'b000, byte_addr[31:3]}] = d;
      ref_write(byte_addr, d, 8'hFF);
   endtask

   typedef struct {
      int          cyc;
      logic        err;
      logic [63:0] data;
   } acc_t;

   acc_t        acc [8192];
   int          wr_ptr = 0;
   int          rd_ptr [2] = '{0, 0};
   int          lat [2] = '{1, 3};
   logic [63:0] last [2] = '{64'h0, 64'h0};
   int          rv_cnt [2] = '{0, 0};
   int          rd_acc_cnt = 0;
   int          run = 0;
   int          stall_seen = 0;
   logic        rv3_log [LOG_SIZE];

   task automatic sb(input int k, input logic rv, input logic er, input logic [63:0] rd);
      acc_t e;
      if (rd_ptr[k] < wr_ptr && cyc == acc[rd_ptr[k]].cyc + lat[k])
         check(k == 0 ? "rvalid_due_l1" : "rvalid_due_l3", 64'(rv), 64'(1));
      if (rv) begin
         rv_cnt[k]++;
         if (rd_ptr[k] >= wr_ptr) begin
            check(k == 0 ? "rvalid_unexpected_l1" : "rvalid_unexpected_l3", 64'(rv), 64'(0));
            last[k] = rd;
         end else begin
            e = acc[rd_ptr[k]];
            check(k == 0 ? "rsp_latency_l1" : "rsp_latency_l3", 64'(cyc), 64'(e.cyc + lat[k]));
            check(k == 0 ? "rsp_err_l1" : "rsp_err_l3", 64'(er), 64'(e.err));
            check(k == 0 ? "rsp_data_l1" : "rsp_data_l3", rd, e.data);
            last[k] = e.data;
            rd_ptr[k]++;
         end
      end else begin
         check(k == 0 ? "err_idle_l1" : "err_idle_l3", 64'(er), 64'(0));
         check(k == 0 ? "rdata_hold_l1" : "rdata_hold_l3", rd, last[k]);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   logic inr;
   always @(negedge clk) begin
      rv3_log[cyc % LOG_SIZE] = rvalid3;
      if (!rst_n) begin
         check("rst_gnt", 64'(gnt1), 64'(0));
         check("rst_mem_req", 64'(mem_req), 64'(0));
         check("rst_rvalid_l1", 64'(rvalid1), 64'(0));
         check("rst_rvalid_l3", 64'(rvalid3), 64'(0));
         rd_ptr[0] = wr_ptr;
         rd_ptr[1] = wr_ptr;
         last[0]   = 64'h0;
         last[1]   = 64'h0;
         run       = 0;
      end else begin
         if (!stall_en) check("gnt_no_stall", 64'(gnt1), 64'(1));
         if (req && !gnt1) begin
            run++;
            stall_seen++;
            check("stall_run_bound", 64'(run <= MAX_STALL), 64'(1));
         end else begin
            run = 0;
         end
         if (req && gnt1) begin
            inr = in_range(addr);
            check("mem_req", 64'(mem_req), 64'(inr));
            check("mem_addr", 64'(mem_addr), 64'(addr >> 3));
            check("mem_we", 64'(mem_we), 64'(we));
            check("mem_wmask", mem_wmask, exp_mask(strb));
            check("mem_wdata", mem_wdata, wdata);
            if (we) begin
               if (inr) ref_write(addr, wdata, strb);
            end else begin
               acc[wr_ptr] = '{cyc, !inr, inr ? ref_read(addr) : 64'h0};
               wr_ptr++;
               rd_acc_cnt++;
            end
         end else begin
            check("mem_req_idle", 64'(mem_req), 64'(0));
         end
         sb(0, rvalid1, err1, rdata1);
         sb(1, rvalid3, err3, rdata3);
      end
   end

   // ------------------------------------------------------------- driver
   task automatic op(input logic [31:0] a, input logic w, input logic [63:0] d,
                     input logic [7:0] s, output int acc_cyc);
      logic got;
      req = 1'b1; addr = a; we = w; wdata = d; strb = s;
      got = 1'b0;
      acc_cyc = -1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (gnt1) begin
            got = 1'b1;
            acc_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      check("grant_timeout", 64'(got), 64'(1));
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_cyc(input int t);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (cyc >= t) break;
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic        exp_req;
      logic [31:0] exp_word;
      logic [63:0] exp_mask;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #5_000_000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c, c0;
      int cs [4];
      logic [31:0] a;
      int          ok;

      vecs[0] = '{32'h8000_0010, 1'b0, 64'h0, 8'hFF, 1'b1, 32'h1000_0002, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[1] = '{32'h8000_0008, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 1'b1, 32'h1000_0001, 64'h0000_0000_FFFF_FFFF};
      vecs[2] = '{32'h8000_0008, 1'b0, 64'h0, 8'hFF, 1'b1, 32'h1000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[3] = '{32'h7FFF_FFF8, 1'b0, 64'h0, 8'hFF, 1'b0, 32'h0FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[4] = '{32'h807F_FFF8, 1'b1, 64'h0102_0304_0506_0708, 8'hA5, 1'b1, 32'h100F_FFFF, 64'hFF00_FF00_00FF_00FF};
      vecs[5] = '{32'h8080_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1'b0, 32'h1010_0000, 64'h0000_0000_0000_00FF};
      vecs[6] = '{32'h807F_FFF8, 1'b0, 64'h0, 8'h00, 1'b1, 32'h100F_FFFF, 64'h0};
      vecs[7] = '{32'h0000_0000, 1'b0, 64'h0, 8'h3C, 1'b0, 32'h0000_0000, 64'h0000_FFFF_FFFF_0000};

      preload(32'h8000_0010, 64'hDEAD_BEEF_0123_4567);
      preload(32'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD);

      // Reset, then check the idle state in the first cycle after release.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_gnt", 64'(gnt1), 64'(1));
      check("reset_rvalid", 64'(rvalid1), 64'(0));
      check("reset_err", 64'(err1), 64'(0));
      check("reset_rdata", rdata1, 64'h0);
      check("reset_rdata_l3", rdata3, 64'h0);
      @(posedge clk); #1;

      // Table-driven vectors, one request per cycle, stalls off.
      for (int i = 0; i < 8; i++) begin
         req = 1'b1; addr = vecs[i].addr; we = vecs[i].we;
         wdata = vecs[i].wdata; strb = vecs[i].strb;
         @(negedge clk);
         check("vec_gnt", 64'(gnt1), 64'(1));
         check("vec_mem_req", 64'(mem_req), 64'(vecs[i].exp_req));
         check("vec_mem_addr", 64'(mem_addr), 64'(vecs[i].exp_word));
         check("vec_mem_wmask", mem_wmask, vecs[i].exp_mask);
         @(posedge clk); #1;
      end
      idle(6);

      // Unstalled read of preloaded data, both latencies.
      op(32'h8000_0010, 1'b0, 64'h0, 8'hFF, c);
      at_cyc(c + 1);
      check("h_read_rvalid_l1", 64'(rvalid1), 64'(1));
      check("h_read_data_l1", rdata1, 64'hDEAD_BEEF_0123_4567);
      check("h_read_early_l3", 64'(rvalid3), 64'(0));
      at_cyc(c + 3);
      check("h_read_rvalid_l3", 64'(rvalid3), 64'(1));
      check("h_read_data_l3", rdata3, 64'hDEAD_BEEF_0123_4567);
      @(posedge clk); #1;

      // Read-back of the partial write: low word new, high word preserved.
      op(32'h8000_0008, 1'b0, 64'h0, 8'hFF, c);
      at_cyc(c + 1);
      check("h_readback_data", rdata1, 64'hAAAA_BBBB_5566_7788);
      @(posedge clk); #1;

      // Out-of-range read returns an error response.
      op(32'h7FFF_FFF8, 1'b0, 64'h0, 8'hFF, c);
      at_cyc(c + 1);
      check("h_oor_rvalid", 64'(rvalid1), 64'(1));
      check("h_oor_err", 64'(err1), 64'(1));
      check("h_oor_rdata", rdata1, 64'h0);
      @(posedge clk); #1;
      idle(4);

      // Back-to-back reads on the ReadLatency=3 instance.
      for (int i = 0; i < 4; i++)
         op(32'h8000_0000 + 32'(8 * i), 1'b0, 64'h0, 8'hFF, cs[i]);
      c0 = cs[0];
      for (int i = 1; i < 4; i++) check("b2b_accept_cycle", 64'(cs[i]), 64'(c0 + i));
      at_cyc(c0 + 8);
      for (int t = 1; t <= 7; t++)
         check("b2b_rvalid_l3", 64'(rv3_log[(c0 + t) % LOG_SIZE]), 64'((t >= 3) && (t <= 6)));
      @(posedge clk); #1;

      // Stall bound and ordering: 2000 sequential reads with stalls on.
      for (int i = 0; i < 2000; i++)
         preload(32'h8000_0000 + 32'(8 * i), {16'hA5A5 ^ 16'(i), 16'(i), 32'(i * 7919)});
      stall_en = 1'b1;
      for (int i = 0; i < 2000; i++)
         op(32'h8000_0000 + 32'(8 * i), 1'b0, 64'h0, 8'hFF, c);
      idle(8);
      check("stalls_observed", 64'(stall_seen > 0), 64'(1));
      check("rvalid_count_l1", 64'(rv_cnt[0]), 64'(rd_acc_cnt));
      check("rvalid_count_l3", 64'(rv_cnt[1]), 64'(rd_acc_cnt));

      // Randomised mix of reads/writes, gaps and stall toggling.
      for (int i = 0; i < 1500; i++) begin
         ok = int'($urandom_range(0, 15));
         if (ok == 0)      a = 32'h7FFF_FFF8 - 32'(8 * $urandom_range(0, 3));
         else if (ok == 1) a = 32'h8080_0000 + 32'(8 * $urandom_range(0, 3));
         else if (ok == 2) a = 32'h807F_FFF8;
         else              a = 32'h8000_0000 + 32'(8 * $urandom_range(0, 63)) + 32'($urandom_range(0, 7));
         stall_en = 1'($urandom_range(0, 1));
         op(a, ($urandom_range(0, 2) == 0), {$urandom, $urandom}, 8'($urandom), c);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(8);
      check("rvalid_count_rand_l1", 64'(rv_cnt[0]), 64'(rd_acc_cnt));
      check("rvalid_count_rand_l3", 64'(rv_cnt[1]), 64'(rd_acc_cnt));

      // Reset with two reads in flight on the ReadLatency=3 instance.
      stall_en = 1'b0;
      op(32'h8000_0010, 1'b0, 64'h0, 8'hFF, c);
      op(32'h8000_0018, 1'b0, 64'h0, 8'hFF, c);
      rst_n = 1'b0;
      stall_en = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      at_cyc(cyc);
      check("rst_mid_gnt", 64'(gnt1), 64'(1));
      for (int i = 0; i < 6; i++) begin
         check("rst_mid_rvalid_l1", 64'(rvalid1), 64'(0));
         check("rst_mid_rvalid_l3", 64'(rvalid3), 64'(0));
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/soc_mem_responder.md
# soc_mem_responder

Memory-side responder for the req/gnt data and instruction ports of the tiny fuzzing SoCs. It sits between a CPU memory port (initiator) and an `sram_mem` instance. It adds pseudo-random grant stalls with a guaranteed forward-progress bound, range checking, and a configurable read-response pipeline with an explicit `rvalid_o`. This exercises core back-pressure paths that the always-granted wiring never reaches.

## Interface
- `Depth`, 1<<20: SRAM depth in 64-bit words.
- `BaseWord`, 64'h10000000: word address of the first SRAM word (0x80000000 >> 3).
- `ReadLatency`, 1: cycles from acceptance to `rvalid_o`; legal range 1..4.
- `StallSeed`, 16'hACE1: LFSR reset value; must be nonzero.
- `MaxStall`, 3: maximum consecutive stalled cycles while `req_i` is high; legal range 1..15.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `stall_en_i` in 1: enables random grant stalls.
- `req_i` in 1: initiator request.
- `gnt_o` out 1: grant. A request is accepted on any cycle with `req_i && gnt_o`.
- `addr_i` in 32: byte address.
- `we_i` in 1: write enable.
- `wdata_i` in 64: write data.
- `strb_i` in 8: byte strobes.
- `rdata_o` out 64: read data.
- `rvalid_o` out 1: read response valid.
- `err_o` out 1: response is an out-of-range error; valid together with `rvalid_o`.
- `mem_req_o`, `mem_we_o` out 1: SRAM request and write enable.
- `mem_addr_o` out 32: SRAM word address, equal to `addr_i >> 3`.
- `mem_wdata_o` out 64: SRAM write data.
- `mem_wmask_o` out 64: SRAM bit mask, with each strobe bit expanded ×8.
- `mem_rdata_i` in 64: SRAM read data, valid one cycle after `mem_req_o`.

## Operation
- **Grant generation:**
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle after reset.
  - `stall_raw = stall_en_i && lfsr[2:0]==3'b000`.
  - `gnt_o = !(stall_raw && stall_cnt < MaxStall)`. The output is combinational from registered state and `stall_en_i` only; it never depends on `req_i` in the same cycle.
  - `stall_cnt` increments on each cycle with `req_i && !gnt_o`. It clears on any grant and whenever `req_i` is low.
- **Acceptance:**
  - `in_range = (addr_i>>3) - BaseWord < Depth`, computed in unsigned 32-bit arithmetic, so addresses below the base wrap and fail the check.
  - An accepted in-range request drives `mem_req_o=1` in the same cycle. `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_wmask_o` pass through combinationally.
  - An out-of-range request never reaches the SRAM.
- **Writes:** writes produce no response, including out-of-range writes, which are silently dropped.
- **Read pipeline:**
  - An accepted read pushes a tag `{valid, err}` into a ReadLatency-deep shift register.
  - When the tag exits, `rvalid_o` pulses for 1 cycle.
    - In-range read: `rdata_o` carries the SRAM data captured at latency 1, delayed by ReadLatency−1 stages.
    - Out-of-range read: `rdata_o=0` and `err_o=1`.
- **Output hold:** `rdata_o` holds its last value when `rvalid_o=0`. `err_o` is 0 whenever `rvalid_o=0`.
- **Throughput:** back-to-back accepted reads are sustained at one per cycle, and responses return in order.

## Timing
- **Reset values:**
  - `gnt_o=1` (reset clears `stall_cnt`; the LFSR seed leaves `stall_raw` at 0 in the first cycle for the default seed).
  - `rvalid_o=0`, `err_o=0`, `rdata_o=0`.
  - `mem_req_o=0` unless `req_i` is asserted. During reset `gnt_o` is forced to 0, so `mem_req_o=0`.
- **Read latency:** exactly ReadLatency cycles from the acceptance edge to `rvalid_o`.
- **Stall bound:** a held request is granted within at most `MaxStall+1` cycles.
- **Simultaneous events:** a response exiting the pipeline and a new acceptance in the same cycle are both honoured.
- **Reset mid-operation:** reset asserted mid-operation flushes all in-flight tags. No `rvalid_o` fires after release for requests accepted before reset.
- **Stall disable:** deasserting `stall_en_i` takes effect in the same cycle.

## Structure
- **Package `soc_mem_pkg`:**
  - `data_t` (64), `strb_t` (8), `addr_t` (32).
  - Function `strb_to_mask(strb_t)` returning the 64-bit mask.
  - Constant `DefaultBaseWord = 64'h10000000`.
- **Sub-module `soc_stall_lfsr`:** 16-bit LFSR with seed parameter, enable input and 16-bit state output.
- **Top level:** the responder contains the stall counter, range check, tag shift register and data delay line.

## Test plan
- **Reset and unstalled read:** reset, `stall_en_i=0`, read 0x80000010 after the SRAM has been preloaded with 64'hDEADBEEF_01234567 → `gnt_o=1`; `mem_addr_o=0x10000002`; `rvalid_o` and that data exactly ReadLatency cycles later.
- **Partial write then read-back:** write 0x80000008, `strb=8'h0F`, data 64'h11223344_55667788 → `mem_wmask_o=64'h00000000_FFFFFFFF`, no `rvalid_o`; read-back returns 64'h????????_55667788, with the upper word unchanged.
- **Out-of-range read:** read 0x7FFFFFF8 → `mem_req_o` stays 0; after ReadLatency cycles `rvalid_o=1`, `err_o=1`, `rdata_o=0`.
- **Stall bound and ordering:** `stall_en_i=1`, hold `req_i` for 2000 reads to sequential addresses →
  - no stall run exceeds `MaxStall` cycles;
  - the count of `rvalid_o` pulses equals the count of accepted reads;
  - the data order matches the address order.
- **Back-to-back with ReadLatency=3:** 4 consecutive reads with the grant held at 1 → 4 consecutive `rvalid_o` cycles starting at cycle 3.
- **Reset mid-operation:** assert `rst_ni=0` with 2 reads in flight → after release `rvalid_o` stays 0 and `gnt_o=1` in the first cycle.
